// File: rtl/efpga_lint_pkg.sv
// Shared constants, decode enum and address decode helper for the LINT responder.
package efpga_lint_pkg;

    // Byte offsets of the register map (bits [1:0] always zero)
    localparam logic [11:0] CTRL_BASE    = 12'h000;
    localparam logic [11:0] STATUS_OFS   = 12'h040;
    localparam logic [11:0] DOORBELL_OFS = 12'h044;
    localparam logic [11:0] ERR_CNT_OFS  = 12'h048;
    localparam logic [11:0] ID_OFS       = 12'h04C;

    localparam logic [31:0] LINT_RSP_ID    = 32'h4C52_0001;
    localparam logic [31:0] LINT_ERR_RDATA = 32'hBAD0_ACCE;

    // Upper bound on the control register bank size
    localparam int unsigned LINT_MAX_REGS = 16;

    typedef enum logic [2:0] {
        CTRL,
        STATUS,
        DOORBELL,
        ERRCNT,
        ID,
        UNMAPPED
    } lint_dec_e;

    // Classify a word-aligned byte offset within the low 4 KiB window
    function automatic lint_dec_e lint_decode(input logic [11:0] ofs, input int unsigned n_regs);
        lint_dec_e dec;
        if (32'(ofs) < 32'(CTRL_BASE) + n_regs * 4) begin
            dec = CTRL;
        end else if (ofs == STATUS_OFS) begin
            dec = STATUS;
        end else if (ofs == DOORBELL_OFS) begin
            dec = DOORBELL;
        end else if (ofs == ERR_CNT_OFS) begin
            dec = ERRCNT;
        end else if (ofs == ID_OFS) begin
            dec = ID;
        end else begin
            dec = UNMAPPED;
        end
        return dec;
    endfunction

endpackage

// File: rtl/efpga_lint_responder_pipe.sv
// Fixed-latency response line: shifts {valid, rdata} RD_LATENCY stages.
module lint_rsp_pipe #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        lint_clk,
    input  logic        lint_rst,
    input  logic        i_valid,
    input  logic [31:0] i_rdata,
    output logic        o_valid,
    output logic [31:0] o_rdata
);

    logic        r_valid [RD_LATENCY];
    logic [31:0] r_rdata [RD_LATENCY];

    // Shift line; reset flushes every in-flight response
    always_ff @(posedge lint_clk) begin
        if (lint_rst) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_valid[i] <= 1'b0;
                r_rdata[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_rdata[0] <= i_rdata;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_rdata = r_rdata[RD_LATENCY-1];

endmodule

// File: rtl/efpga_lint_responder.sv
// LINT slave terminating the SoC bridge: control bank, status, doorbell, error counter, ID.
module efpga_lint_responder
    import efpga_lint_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned N_REGS     = 16,
    parameter int unsigned N_EVENTS   = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                   lint_clk,
    input  logic                   lint_rst,
    input  logic                   lint_REQ,
    output logic                   lint_GNT,
    input  logic [ADDR_WIDTH-1:0]  lint_ADDR,
    input  logic                   lint_WEN,
    input  logic [3:0]             lint_BE,
    input  logic [31:0]            lint_WDATA,
    output logic [31:0]            lint_RDATA,
    output logic                   lint_VALID,
    input  logic                   hold_i,
    input  logic [31:0]            status_i,
    output logic [N_REGS*32-1:0]   ctrl_o,
    output logic [N_EVENTS-1:0]    event_o
);

    logic                           w_txn;
    logic                           w_wr;
    logic [11:0]                    w_ofs;
    logic [3:0]                     w_idx;
    lint_dec_e                      w_dec;
    logic [31:0]                    w_rdata;
    logic [LINT_MAX_REGS-1:0][31:0] w_ctrl_all;
    logic [31:0]                    r_ctrl [N_REGS];
    logic [15:0]                    r_err_cnt;
    logic [N_EVENTS-1:0]            r_event;
    logic                           w_unused;

    assign lint_GNT = lint_REQ & ~hold_i;
    // Grants seen while in reset are discarded entirely
    assign w_txn    = lint_GNT & ~lint_rst;
    assign w_wr     = w_txn & ~lint_WEN;
    assign w_ofs    = {lint_ADDR[11:2], 2'b00};
    assign w_idx    = lint_ADDR[5:2];
    assign w_dec    = (|lint_ADDR[ADDR_WIDTH-1:12]) ? UNMAPPED : lint_decode(w_ofs, N_REGS);
    assign w_unused = ^lint_ADDR[1:0];

    for (genvar g = 0; g < LINT_MAX_REGS; g++) begin : g_ctrl
        if (g < N_REGS) begin : g_reg
            // Byte-enabled control register write
            always_ff @(posedge lint_clk) begin
                if (lint_rst) begin
                    r_ctrl[g] <= '0;
                end else if (w_wr && w_dec == CTRL && w_idx == 4'(g)) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (lint_BE[b]) begin
                            r_ctrl[g][b*8 +: 8] <= lint_WDATA[b*8 +: 8];
                        end
                    end
                end
            end
            assign w_ctrl_all[g]       = r_ctrl[g];
            assign ctrl_o[g*32 +: 32]  = r_ctrl[g];
        end else begin : g_none
            assign w_ctrl_all[g] = '0;
        end
    end

    // Read data mux; writes always respond with zero
    always_comb begin
        w_rdata = '0;
        if (w_txn && lint_WEN) begin
            case (w_dec)
                CTRL:     w_rdata = w_ctrl_all[w_idx];
                STATUS:   w_rdata = status_i;
                DOORBELL: w_rdata = '0;
                ERRCNT:   w_rdata = {16'h0000, r_err_cnt};
                ID:       w_rdata = LINT_RSP_ID;
                UNMAPPED: w_rdata = LINT_ERR_RDATA;
                default:  w_rdata = '0;
            endcase
        end
    end

    // Saturating unmapped-access counter; a write to ERR_CNT clears it and wins
    always_ff @(posedge lint_clk) begin
        if (lint_rst) begin
            r_err_cnt <= '0;
        end else if (w_wr && w_dec == ERRCNT) begin
            r_err_cnt <= '0;
        end else if (w_txn && w_dec == UNMAPPED && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    // Doorbell: one-cycle event pulse following the granted write
    always_ff @(posedge lint_clk) begin
        if (lint_rst) begin
            r_event <= '0;
        end else if (w_wr && w_dec == DOORBELL) begin
            r_event <= lint_WDATA[N_EVENTS-1:0];
        end else begin
            r_event <= '0;
        end
    end

    assign event_o = r_event;

    lint_rsp_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe (
        .lint_clk (lint_clk),
        .lint_rst (lint_rst),
        .i_valid  (w_txn),
        .i_rdata  (w_rdata),
        .o_valid  (lint_VALID),
        .o_rdata  (lint_RDATA)
    );

endmodule

// File: tb/tb_efpga_lint_responder.sv
// Scoreboard bench: driver pushes expected responses, monitor pops on each VALID.
module tb_efpga_lint_responder;

    localparam int unsigned AW  = 20;
    localparam int unsigned NR  = 16;
    localparam int unsigned NE  = 16;
    localparam int unsigned LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              gnt;
    logic [AW-1:0]     addr;
    logic              wen;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              valid;
    logic              hold;
    logic [31:0]       status;
    logic [NR*32-1:0]  ctrl;
    logic [NE-1:0]     ev;

    typedef struct {
        logic [31:0] d;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc  = 0;
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    efpga_lint_responder #(
        .ADDR_WIDTH(AW),
        .N_REGS    (NR),
        .N_EVENTS  (NE),
        .RD_LATENCY(LAT)
    ) dut (
        .lint_clk  (clk),
        .lint_rst  (rst),
        .lint_REQ  (req),
        .lint_GNT  (gnt),
        .lint_ADDR (addr),
        .lint_WEN  (wen),
        .lint_BE   (be),
        .lint_WDATA(wdata),
        .lint_RDATA(rdata),
        .lint_VALID(valid),
        .hold_i    (hold),
        .status_i  (status),
        .ctrl_o    (ctrl),
        .event_o   (ev)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the granting posedge
    task automatic txn(input logic [AW-1:0] a, input logic rd, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] exp_d, input bit expect_rsp);
        bit granted = 0;
        req = 1'b1; addr = a; wen = rd; be = b; wdata = wd;
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                granted = 1;
                if (expect_rsp) q.push_back('{d: exp_d, cyc: cyc + LAT});
            end
        end
        if (!granted) begin
            nvec++; nerr++;
            $display("FAIL grant_timeout: got no grant expected grant for addr %h", a);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Monitor: every VALID must match the oldest outstanding expectation and its cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_valid: got VALID rdata %h expected no response", rdata);
                end else begin
                    e = q.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; hold = 1'b0; addr = '0; wen = 1'b1; be = '0;
        wdata = '0; status = 32'h0;

        // Request during reset: granted combinationally but discarded
        @(posedge clk); #1;
        req = 1'b1; wen = 1'b0; addr = 20'h00000; be = 4'hF; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("gnt_in_reset", {31'b0, gnt}, 32'd1);
        repeat (3) @(posedge clk);
        #1; req = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_event", {16'h0, ev}, 32'h0);
        chk("rst_ctrl0", ctrl[31:0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("no_side_effect_ctrl0", ctrl[31:0], 32'h0);

        // Byte-enabled write then read
        txn(20'h004, 1'b0, 4'b0101, 32'hA5A5_A5A5, 32'h0, 1);
        txn(20'h004, 1'b1, 4'b0000, 32'h0, 32'h00A5_00A5, 1);
        chk("ctrl1_out", ctrl[63:32], 32'h00A5_00A5);

        // Back-to-back write/read of reg 0
        txn(20'h000, 1'b0, 4'b1111, 32'h1234_5678, 32'h0, 1);
        txn(20'h000, 1'b1, 4'b0000, 32'h0, 32'h1234_5678, 1);

        // BE=0 write is a no-op that still responds
        txn(20'h004, 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1);
        txn(20'h004, 1'b1, 4'b0000, 32'h0, 32'h00A5_00A5, 1);

        // Last control register
        txn(20'h03C, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1);
        txn(20'h03C, 1'b1, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1);
        chk("ctrl15_out", ctrl[511:480], 32'hDEAD_BEEF);

        // Doorbell pulse
        txn(20'h044, 1'b0, 4'b0000, 32'h0000_8001, 32'h0, 1);
        @(negedge clk);
        chk("event_pulse", {16'h0, ev}, 32'h0000_8001);
        @(negedge clk);
        chk("event_clear", {16'h0, ev}, 32'h0);
        @(posedge clk); #1;
        txn(20'h044, 1'b1, 4'b0000, 32'h0, 32'h0, 1);

        // ID, write to RO dropped, status
        txn(20'h04C, 1'b1, 4'b0000, 32'h0, 32'h4C52_0001, 1);
        txn(20'h04C, 1'b0, 4'b1111, 32'h1111_1111, 32'h0, 1);
        txn(20'h04C, 1'b1, 4'b0000, 32'h0, 32'h4C52_0001, 1);
        status = 32'hCAFE_F00D;
        txn(20'h040, 1'b1, 4'b0000, 32'h0, 32'hCAFE_F00D, 1);

        // Unmapped reads and counter (RO write above was not counted)
        txn(20'h100, 1'b1, 4'b0000, 32'h0, 32'hBAD0_ACCE, 1);
        txn(20'h100, 1'b1, 4'b0000, 32'h0, 32'hBAD0_ACCE, 1);
        txn(20'h100, 1'b1, 4'b0000, 32'h0, 32'hBAD0_ACCE, 1);
        txn(20'h048, 1'b1, 4'b0000, 32'h0, 32'h0000_0003, 1);

        // Back-pressure: request held off for 5 cycles, status read at grant time
        hold = 1'b1; req = 1'b1; addr = 20'h040; wen = 1'b1; status = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gnt_held", {31'b0, gnt}, 32'd0);
        end
        @(posedge clk); #1;
        hold = 1'b0; status = 32'h5555_AAAA;
        txn(20'h040, 1'b1, 4'b0000, 32'h0, 32'h5555_AAAA, 1);

        // Saturation
        for (int i = 0; i < 70000; i++) begin
            txn(20'h100, 1'b1, 4'b0000, 32'h0, 32'hBAD0_ACCE, 1);
        end
        txn(20'h048, 1'b1, 4'b0000, 32'h0, 32'h0000_FFFF, 1);
        txn(20'h048, 1'b0, 4'b0000, 32'h0, 32'h0, 1);
        txn(20'h048, 1'b1, 4'b0000, 32'h0, 32'h0, 1);

        // Reset mid-flight: the ID read must never respond
        txn(20'h04C, 1'b1, 4'b0000, 32'h0, 32'h0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_rst_valid", {31'b0, valid}, 32'd0);
        chk("post_rst_rdata", rdata, 32'h0);
        chk("post_rst_event", {16'h0, ev}, 32'h0);
        chk("post_rst_ctrl0", ctrl[31:0], 32'h0);
        chk("post_rst_ctrl15", ctrl[511:480], 32'h0);

        // Drain and confirm every expected response arrived
        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
